// File: rtl/fss_pkg.sv
// Shared types and display-field layout for the memory display scanner.
// The display word is {address low byte, 16-bit data word}.
package fss_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DWELL
    } scanner_state_t;

    localparam int unsigned DISP_WIDTH    = 24;
    localparam int unsigned DISP_ADDR_MSB = 23;
    localparam int unsigned DISP_ADDR_LSB = 16;
    localparam int unsigned DISP_DATA_MSB = 15;
    localparam int unsigned DISP_DATA_LSB = 0;

endpackage

// File: rtl/rising_edge_detect.sv
// Registered single-cycle pulse on each rising edge of a level input.
// The pulse appears one cycle after the level is first seen high.
module rising_edge_detect (
    input  logic i_clk,
    input  logic i_nreset,
    input  logic i_level,
    output logic o_pulse
);

    logic prev_q;
    logic prev_d;
    logic pulse_q;
    logic pulse_d;

    always_comb begin
        prev_d  = i_level;
        pulse_d = i_level & ~prev_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_pulse = pulse_q;

endmodule

// File: rtl/mem_display_scanner.sv
// Walks an address window on BRAM port B and shows {addr[7:0], data} on the
// six-digit display, advancing on a dwell timer or on a step input.
module mem_display_scanner
    import fss_pkg::*;
#(
    parameter int unsigned P_ADDRESS_WIDTH = 11,
    parameter int unsigned P_DATA_WIDTH    = 16,
    parameter int unsigned P_READ_LATENCY  = 1,
    parameter int unsigned P_DWELL_CYCLES  = 50_000_000
) (
    input  logic                       I_CLK,
    input  logic                       I_NRESET,
    input  logic                       I_ENABLE,
    input  logic                       I_AUTO,
    input  logic                       I_STEP,
    input  logic [P_ADDRESS_WIDTH-1:0] I_START_ADDRESS,
    input  logic [P_ADDRESS_WIDTH-1:0] I_END_ADDRESS,
    input  logic [P_DATA_WIDTH-1:0]    I_MEM_DATA_B,
    output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS_B,
    output logic [DISP_WIDTH-1:0]      O_DISPLAY_BITS,
    output logic                       O_VALID
);

    localparam int unsigned LAT_W   = $clog2(P_READ_LATENCY + 1);
    localparam int unsigned DWELL_W = $clog2(P_DWELL_CYCLES);

    localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(P_READ_LATENCY);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(P_DWELL_CYCLES - 1);

    scanner_state_t             state_q;
    scanner_state_t             state_d;
    logic [P_ADDRESS_WIDTH-1:0] addr_q;
    logic [P_ADDRESS_WIDTH-1:0] addr_d;
    logic [DISP_WIDTH-1:0]      disp_q;
    logic [DISP_WIDTH-1:0]      disp_d;
    logic                       valid_q;
    logic                       valid_d;
    logic [LAT_W-1:0]           lat_q;
    logic [LAT_W-1:0]           lat_d;
    logic [DWELL_W-1:0]         dwell_q;
    logic [DWELL_W-1:0]         dwell_d;

    logic                       step_pulse;
    logic                       advance;
    logic [P_ADDRESS_WIDTH-1:0] next_addr;

    rising_edge_detect u_step_edge (
        .i_clk    (I_CLK),
        .i_nreset (I_NRESET),
        .i_level  (I_STEP),
        .o_pulse  (step_pulse)
    );

    // Window bounds are read live here, so changes only matter at an advance.
    always_comb begin
        if (addr_q == I_END_ADDRESS) begin
            next_addr = I_START_ADDRESS;
        end else begin
            next_addr = addr_q + P_ADDRESS_WIDTH'(1);
        end
        advance = (I_AUTO && (dwell_q == DWELL_LAST)) || step_pulse;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        disp_d  = disp_q;
        valid_d = valid_q;
        lat_d   = lat_q;
        dwell_d = dwell_q;

        if (!I_ENABLE) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_d  = I_START_ADDRESS;
                    lat_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        disp_d[DISP_ADDR_MSB:DISP_ADDR_LSB] = 8'(addr_q);
                        disp_d[DISP_DATA_MSB:DISP_DATA_LSB] = 16'(I_MEM_DATA_B);
                        valid_d = 1'b1;
                        dwell_d = '0;
                        state_d = S_DWELL;
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                S_DWELL: begin
                    // Live view: keep refreshing the data field for the held address.
                    disp_d[DISP_DATA_MSB:DISP_DATA_LSB] = 16'(I_MEM_DATA_B);
                    if (advance) begin
                        addr_d  = next_addr;
                        lat_d   = '0;
                        state_d = S_WAIT;
                    end else if (dwell_q == DWELL_LAST) begin
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_NRESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            disp_q  <= '0;
            valid_q <= 1'b0;
            lat_q   <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            disp_q  <= disp_d;
            valid_q <= valid_d;
            lat_q   <= lat_d;
            dwell_q <= dwell_d;
        end
    end

    assign O_MEM_ADDRESS_B = addr_q;
    assign O_DISPLAY_BITS  = disp_q;
    assign O_VALID         = valid_q;

endmodule

// File: tb/tb_mem_display_scanner.sv
// Self-checking bench for mem_display_scanner with a behavioural BRAM and a
// timing/sequence model derived from the scan rules.
module tb_mem_display_scanner;

    localparam int unsigned AW     = 11;
    localparam int unsigned DW     = 16;
    localparam int unsigned LAT    = 1;
    localparam int unsigned DWELL  = 4;
    localparam int unsigned PERIOD = DWELL + LAT + 1;
    localparam int unsigned DEPTH  = 1 << AW;

    logic          clk;
    logic          nreset;
    logic          enable;
    logic          auto_mode;
    logic          step;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] dut_addr;
    logic [23:0]   dut_disp;
    logic          dut_valid;

    logic [DW-1:0] mem [0:DEPTH-1];

    int checks;
    int errors;

    mem_display_scanner #(
        .P_ADDRESS_WIDTH (AW),
        .P_DATA_WIDTH    (DW),
        .P_READ_LATENCY  (LAT),
        .P_DWELL_CYCLES  (DWELL)
    ) dut (
        .I_CLK           (clk),
        .I_NRESET        (nreset),
        .I_ENABLE        (enable),
        .I_AUTO          (auto_mode),
        .I_STEP          (step),
        .I_START_ADDRESS (start_addr),
        .I_END_ADDRESS   (end_addr),
        .I_MEM_DATA_B    (mem_rdata),
        .O_MEM_ADDRESS_B (dut_addr),
        .O_DISPLAY_BITS  (dut_disp),
        .O_VALID         (dut_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read BRAM port B.
    always @(posedge clk) mem_rdata <= mem[dut_addr];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [AW-1:0] model_next(input logic [AW-1:0] a,
                                                 input logic [AW-1:0] s,
                                                 input logic [AW-1:0] e);
        int unsigned v;
        if (a == e) return s;
        v = (int'(a) + 1) % DEPTH;
        return AW'(v);
    endfunction

    function automatic logic [23:0] model_disp(input logic [AW-1:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return {lo, mem[a]};
    endfunction

    task automatic do_reset();
        nreset = 1'b0;
        enable = 1'b0;
        step   = 1'b0;
        ticks(2);
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        enable = 1'b1;
        ticks(3);
        checks++;
        if (dut_addr !== 11'h000) begin
            errors++; $display("FAIL reset_addr got %h exp 000", dut_addr);
        end
        checks++;
        if (dut_disp !== 24'h000000) begin
            errors++; $display("FAIL reset_disp got %h exp 000000", dut_disp);
        end
        checks++;
        if (dut_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b exp 0", dut_valid);
        end
        enable = 1'b0;
        nreset = 1'b1;
        start_addr = 11'h010;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (dut_addr !== 11'h000 || dut_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold cyc=%0d got addr %h valid %b exp 000/0", i, dut_addr, dut_valid);
            end
        end
    endtask

    task automatic test_auto_scan();
        do_reset();
        auto_mode = 1'b1; start_addr = 11'h010; end_addr = 11'h012;
        enable = 1'b1;
        tick(); // edge 0
        checks++;
        if (dut_addr !== 11'h010 || dut_valid !== 1'b0) begin
            errors++; $display("FAIL auto_e0 got addr %h valid %b exp 010/0", dut_addr, dut_valid);
        end
        tick(); // edge 1
        checks++;
        if (dut_valid !== 1'b0) begin
            errors++; $display("FAIL auto_e1_valid got %b exp 0", dut_valid);
        end
        tick(); // edge 2
        checks++;
        if (dut_disp !== 24'h10BEEF || dut_valid !== 1'b1) begin
            errors++; $display("FAIL auto_e2 got %h valid %b exp 10beef/1", dut_disp, dut_valid);
        end
        ticks(3); // edge 5
        checks++;
        if (dut_addr !== 11'h010) begin
            errors++; $display("FAIL auto_e5_addr got %h exp 010", dut_addr);
        end
        tick(); // edge 6
        checks++;
        if (dut_addr !== 11'h011) begin
            errors++; $display("FAIL auto_e6_addr got %h exp 011", dut_addr);
        end
        ticks(2); // edge 8
        checks++;
        if (dut_disp !== 24'h111234) begin
            errors++; $display("FAIL auto_e8_disp got %h exp 111234", dut_disp);
        end
        ticks(6); // edge 14
        checks++;
        if (dut_disp !== 24'h1200FF) begin
            errors++; $display("FAIL auto_e14_disp got %h exp 1200ff", dut_disp);
        end
        ticks(4); // edge 18
        checks++;
        if (dut_addr !== 11'h010) begin
            errors++; $display("FAIL auto_e18_wrap got %h exp 010", dut_addr);
        end
        ticks(2); // edge 20
        checks++;
        if (dut_disp !== 24'h10BEEF) begin
            errors++; $display("FAIL auto_e20_disp got %h exp 10beef", dut_disp);
        end
        enable = 1'b0;
        tick();
    endtask

    // Auto-mode run over one window, checked every cycle against the
    // word-sequence and period model.
    task automatic run_window_check(input logic [AW-1:0] s, input logic [AW-1:0] e,
                                    input int words, input string tag);
        logic [AW-1:0] seq [$];
        int k;
        seq.push_back(s);
        for (int i = 1; i <= words; i++) seq.push_back(model_next(seq[i-1], s, e));
        start_addr = s; end_addr = e; auto_mode = 1'b1;
        enable = 1'b1;
        for (int c = 0; c < words * int'(PERIOD); c++) begin
            tick();
            k = c / int'(PERIOD);
            checks++;
            if (dut_addr !== seq[k]) begin
                errors++; $display("FAIL %s_addr c=%0d got %h exp %h", tag, c, dut_addr, seq[k]);
            end
            if (c >= int'(LAT) + 1) begin
                k = (c - int'(LAT) - 1) / int'(PERIOD);
                checks++;
                if (dut_disp !== model_disp(seq[k]) || dut_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_disp c=%0d got %h valid %b exp %h/1", tag, c, dut_disp, dut_valid, model_disp(seq[k]));
                end
            end
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_wrap_window();
        do_reset();
        run_window_check(11'h7FE, 11'h001, 5, "wrap");
        run_window_check(11'h010, 11'h010, 3, "single");
        checks++;
        if (dut_disp !== 24'h10BEEF) begin
            errors++; $display("FAIL single_hold got %h exp 10beef", dut_disp);
        end
    endtask

    task automatic test_random_windows();
        logic [AW-1:0] s;
        logic [AW-1:0] e;
        do_reset();
        for (int n = 0; n < 6; n++) begin
            s = AW'($urandom_range(0, DEPTH - 1));
            e = AW'((int'(s) + int'($urandom_range(0, 4))) % DEPTH);
            run_window_check(s, e, 6, "rand");
        end
    endtask

    task automatic test_step_mode();
        do_reset();
        auto_mode = 1'b0; start_addr = 11'h010; end_addr = 11'h012;
        enable = 1'b1;
        step   = 1'b1;     // rises while not dwelling: must be discarded
        tick();
        tick();
        step = 1'b0;
        tick();
        checks++;
        if (dut_disp !== 24'h10BEEF || dut_valid !== 1'b1) begin
            errors++; $display("FAIL step_first got %h valid %b exp 10beef/1", dut_disp, dut_valid);
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i % 10 == 9) begin
                checks++;
                if (dut_disp !== 24'h10BEEF || dut_addr !== 11'h010) begin
                    errors++; $display("FAIL step_hold i=%0d got %h addr %h exp 10beef/010", i, dut_disp, dut_addr);
                end
            end
        end
        step = 1'b1;
        tick();
        checks++;
        if (dut_addr !== 11'h010) begin
            errors++; $display("FAIL step_lat1 got %h exp 010", dut_addr);
        end
        tick();
        checks++;
        if (dut_addr !== 11'h011) begin
            errors++; $display("FAIL step_lat2 got %h exp 011", dut_addr);
        end
        ticks(2);
        checks++;
        if (dut_disp !== 24'h111234) begin
            errors++; $display("FAIL step_disp got %h exp 111234", dut_disp);
        end
        ticks(50);
        checks++;
        if (dut_addr !== 11'h011 || dut_disp !== 24'h111234) begin
            errors++; $display("FAIL step_held got addr %h disp %h exp 011/111234", dut_addr, dut_disp);
        end
    endtask

    // Runs directly after test_step_mode, while dwelling on 0x011.
    task automatic test_live_view();
        mem[11'h011] = 16'h5A5A;
        tick();
        checks++;
        if (dut_disp !== 24'h111234) begin
            errors++; $display("FAIL live_early got %h exp 111234", dut_disp);
        end
        tick();
        checks++;
        if (dut_disp !== 24'h115A5A) begin
            errors++; $display("FAIL live_update got %h exp 115a5a", dut_disp);
        end
        mem[11'h011] = 16'h1234;
        step = 1'b0;
        enable = 1'b0;
        tick();
    endtask

    task automatic test_step_and_timer();
        do_reset();
        auto_mode = 1'b1; start_addr = 11'h010; end_addr = 11'h012;
        enable = 1'b1;
        ticks(5);          // edge 4
        step = 1'b1;
        ticks(2);          // edge 6: timer and step pulse coincide
        checks++;
        if (dut_addr !== 11'h011) begin
            errors++; $display("FAIL both_e6 got %h exp 011", dut_addr);
        end
        ticks(5);          // edge 11
        checks++;
        if (dut_addr !== 11'h011) begin
            errors++; $display("FAIL both_e11 got %h exp 011", dut_addr);
        end
        tick();            // edge 12
        checks++;
        if (dut_addr !== 11'h012) begin
            errors++; $display("FAIL both_e12 got %h exp 012", dut_addr);
        end
        step = 1'b0;
        enable = 1'b0;
        tick();
    endtask

    task automatic test_disable_and_reset();
        do_reset();
        auto_mode = 1'b1; start_addr = 11'h010; end_addr = 11'h012;
        enable = 1'b1;
        ticks(7);          // edge 6: now waiting on 0x011
        enable = 1'b0;
        tick();
        checks++;
        if (dut_valid !== 1'b0 || dut_disp !== 24'h10BEEF || dut_addr !== 11'h011) begin
            errors++;
            $display("FAIL disable got valid %b disp %h addr %h exp 0/10beef/011", dut_valid, dut_disp, dut_addr);
        end
        ticks(3);
        checks++;
        if (dut_valid !== 1'b0 || dut_disp !== 24'h10BEEF || dut_addr !== 11'h011) begin
            errors++;
            $display("FAIL disable_hold got valid %b disp %h addr %h exp 0/10beef/011", dut_valid, dut_disp, dut_addr);
        end
        enable = 1'b1;
        tick();            // edge 0 of restart
        checks++;
        if (dut_addr !== 11'h010 || dut_valid !== 1'b0) begin
            errors++; $display("FAIL reenable_addr got %h valid %b exp 010/0", dut_addr, dut_valid);
        end
        ticks(2);
        checks++;
        if (dut_disp !== 24'h10BEEF || dut_valid !== 1'b1) begin
            errors++; $display("FAIL reenable_disp got %h valid %b exp 10beef/1", dut_disp, dut_valid);
        end
        ticks(4);          // edge 6: waiting on 0x011 again
        checks++;
        if (dut_addr !== 11'h011) begin
            errors++; $display("FAIL pre_reset_addr got %h exp 011", dut_addr);
        end
        nreset = 1'b0;
        tick();
        checks++;
        if (dut_addr !== 11'h000 || dut_disp !== 24'h000000 || dut_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait got addr %h disp %h valid %b exp 000/000000/0", dut_addr, dut_disp, dut_valid);
        end
        nreset = 1'b1;
        enable = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nreset = 1'b0; enable = 1'b0; auto_mode = 1'b1; step = 1'b0;
        start_addr = '0; end_addr = '0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'($urandom);
        mem[11'h010] = 16'hBEEF;
        mem[11'h011] = 16'h1234;
        mem[11'h012] = 16'h00FF;
        #1;

        test_reset();
        test_auto_scan();
        test_step_mode();
        test_live_view();
        test_step_and_timer();
        test_wrap_window();
        test_random_windows();
        test_disable_and_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
